// File: rtl/cam_pkt_scheduler.sv
// Packetizer between the camera FIFO and the GigE transmit path: waits for a full
// payload and a ready MAC, then emits one header word followed by PKT_WORDS FIFO words.
module cam_pkt_scheduler #(
    parameter int PKT_WORDS  = 128,
    parameter int GAP_CYCLES = 12,
    parameter int FIFO_CNT_W = 11
) (
    input  logic                  clk_125M,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [FIFO_CNT_W-1:0] fifo_rd_count,
    input  logic [63:0]           fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [63:0]           tx_data,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic [15:0]           FS_mark,
    output logic [15:0]           pkt_seq,
    output logic                  busy,
    output logic                  overrun
);

    localparam int PKT_CLOG = $clog2(PKT_WORDS);
    localparam int GAP_CLOG = $clog2(GAP_CYCLES);
    localparam int CNT_W    = ((PKT_CLOG > GAP_CLOG) ? PKT_CLOG : GAP_CLOG) + 1;

    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_WORDS - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(PKT_WORDS - 2);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [15:0]      PKT_LEN  = 16'(PKT_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HDR,
        PAYLOAD,
        GAP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             rd_en_next;
    logic             flag_reg;
    logic             start;
    logic             apply;
    logic             cnt_last_pkt;
    logic             cnt_last_gap;

    assign start        = enable && tx_ready && (32'(fifo_rd_count) >= 32'(PKT_WORDS));
    assign cnt_last_pkt = (cnt_reg == PKT_LAST);
    assign cnt_last_gap = (cnt_reg == GAP_LAST);
    // Frame marks never change mid-packet, so a header and its payload always agree.
    assign apply        = flag_reg && (state_reg == IDLE || state_reg == WAIT || state_reg == GAP);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rd_en_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = WAIT;
            end
            WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = HDR;
                    rd_en_next = 1'b1;
                end
            end
            HDR: begin
                state_next = PAYLOAD;
                cnt_next   = '0;
                rd_en_next = 1'b1;
            end
            PAYLOAD: begin
                // The read strobe leads the payload by one cycle, so it drops one word early.
                rd_en_next = (cnt_reg < RD_LAST);
                if (cnt_last_pkt) begin
                    state_next = GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_last_gap) begin
                    state_next = enable ? WAIT : IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_125M or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            fifo_rd_en <= 1'b0;
            flag_reg   <= 1'b0;
            FS_mark    <= '0;
            pkt_seq    <= '0;
            overrun    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            fifo_rd_en <= rd_en_next;

            // A pulse in the apply cycle belongs to a newer frame and re-arms the flag.
            if (apply) begin
                flag_reg <= frame_start;
                FS_mark  <= FS_mark + 16'd1;
                pkt_seq  <= '0;
            end else begin
                if (frame_start) flag_reg <= 1'b1;
                if (tx_eop) pkt_seq <= pkt_seq + 16'd1;
            end

            if (!enable) begin
                overrun <= 1'b0;
            end else if (&fifo_rd_count) begin
                overrun <= 1'b1;
            end
        end
    end

    assign tx_valid = (state_reg == HDR) || (state_reg == PAYLOAD);
    assign tx_sop   = (state_reg == HDR);
    assign tx_eop   = (state_reg == PAYLOAD) && cnt_last_pkt;
    assign busy     = (state_reg == HDR) || (state_reg == PAYLOAD) || (state_reg == GAP);

    always_comb begin
        tx_data = '0;
        if (state_reg == HDR) begin
            tx_data = {FS_mark, pkt_seq, PKT_LEN, 16'hA55A};
        end else if (state_reg == PAYLOAD) begin
            tx_data = fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_cam_pkt_scheduler.sv
// Directed bench for cam_pkt_scheduler: a counting FIFO model feeds payload words and
// each packet is checked word by word against hand-derived header and data values.
module tb_cam_pkt_scheduler;

    localparam int P = 128;
    localparam int G = 12;
    localparam int PERIOD = P + G + 2;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic [10:0] fifo_rd_count;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        tx_ready;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic [15:0] FS_mark;
    logic [15:0] pkt_seq;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_pulses = 0;
    int last_sop = 0;
    longint exp_word = 1;

    cam_pkt_scheduler #(
        .PKT_WORDS (P),
        .GAP_CYCLES(G),
        .FIFO_CNT_W(11)
    ) dut (
        .clk_125M     (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_start  (frame_start),
        .fifo_rd_count(fifo_rd_count),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx_ready     (tx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_sop       (tx_sop),
        .tx_eop       (tx_eop),
        .FS_mark      (FS_mark),
        .pkt_seq      (pkt_seq),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Non-FWFT FIFO preloaded with 1,2,3,...: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= 64'(rd_pulses + 1);
            rd_pulses    <= rd_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic run_packet(input logic [15:0] exp_fs, input logic [15:0] exp_seq,
                              input int exp_period, input int fs_at, input int drop_at,
                              input int rst_at);
        int waited = 0;
        int rd0;
        do begin
            @(negedge clk);
            waited++;
        end while (!tx_sop && waited < 400);
        if (!tx_sop) begin
            check("sop_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_period > 0) check("period", 64'(cyc - last_sop), 64'(exp_period));
        last_sop = cyc;
        check("header", tx_data, {exp_fs, exp_seq, 16'h0080, 16'hA55A});
        check("hdr_rd_en", 64'(fifo_rd_en), 64'd1);
        rd0 = rd_pulses;
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            frame_start = (fs_at > 0) && (k == fs_at || k == fs_at + 1);
            if (k == drop_at) tx_ready = 1'b0;
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_outputs", 64'({tx_valid, tx_sop, tx_eop, fifo_rd_en, busy, overrun,
                                          FS_mark, pkt_seq}), 64'd0);
                check("rst_data", tx_data, 64'd0);
                $display("pkt fs=%h seq=%h sop_cycle=%0d truncated at word %0d", exp_fs, exp_seq,
                         last_sop, k);
                return;
            end
            check("flags", 64'({tx_valid, tx_sop, tx_eop}), 64'({1'b1, 1'b0, (k == P)}));
            check("payload", tx_data, 64'(exp_word));
            exp_word++;
        end
        frame_start = 1'b0;
        check("rd_count", 64'(rd_pulses - rd0), 64'(P));
        @(negedge clk);
        check("gap_state", 64'({tx_valid, fifo_rd_en, busy}), 64'(3'b001));
        check("seq_inc", 64'(pkt_seq), 64'(exp_seq + 16'd1));
        check("fs_gap0", 64'(FS_mark), 64'(exp_fs));
        $display("pkt fs=%h seq=%h sop_cycle=%0d words=%0d", exp_fs, exp_seq, last_sop, P);
    endtask

    initial begin
        int rd0;
        rst_n         = 1'b0;
        enable        = 1'b0;
        frame_start   = 1'b0;
        fifo_rd_count = '0;
        tx_ready      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({tx_valid, tx_sop, tx_eop, fifo_rd_en, busy, overrun,
                                    FS_mark, pkt_seq}), 64'd0);
        check("reset_data", tx_data, 64'd0);
        rst_n = 1'b1;

        // Payload threshold: one word short holds off, a full payload starts.
        enable   = 1'b1;
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        fifo_rd_count = 11'(P - 1);
        repeat (10) @(negedge clk);
        check("hold_off", 64'({busy, fifo_rd_en, 16'(rd_pulses)}), 64'd0);
        fifo_rd_count = 11'(P);
        run_packet(16'h0000, 16'h0000, 0, 0, 0, 0);

        // Continuous traffic.
        fifo_rd_count = 11'd256;
        run_packet(16'h0000, 16'h0001, PERIOD, 0, 0, 0);
        run_packet(16'h0000, 16'h0002, PERIOD, 0, 0, 0);

        // Double frame_start mid-payload: single increment, applied only in GAP.
        run_packet(16'h0000, 16'h0003, PERIOD, 40, 0, 0);
        repeat (2) @(negedge clk);
        check("fs_applied", 64'({FS_mark, pkt_seq}), 64'({16'h0001, 16'h0000}));
        run_packet(16'h0001, 16'h0000, PERIOD, 0, 0, 0);

        // MAC not ready: stay in WAIT without reading.
        tx_ready = 1'b0;
        rd0 = rd_pulses;
        repeat (200) @(negedge clk);
        check("not_ready", 64'({busy, 16'(rd_pulses - rd0)}), 64'd0);
        tx_ready = 1'b1;
        run_packet(16'h0001, 16'h0001, 0, 0, 60, 0);
        rd0 = rd_pulses;
        repeat (30) @(negedge clk);
        check("ready_dropped", 64'({busy, 16'(rd_pulses - rd0)}), 64'd0);
        check("fs_no_extra", 64'(FS_mark), 64'h0001);
        tx_ready = 1'b1;

        // Asynchronous reset mid-packet, then a clean restart.
        run_packet(16'h0001, 16'h0002, 0, 0, 0, 50);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_word = longint'(rd_pulses) + 1;
        run_packet(16'h0000, 16'h0000, 0, 0, 0, 0);

        // Overrun is sticky through traffic, cleared by enable=0.
        fifo_rd_count = 11'h7FF;
        @(negedge clk);
        fifo_rd_count = 11'd256;
        @(negedge clk);
        check("overrun_set", 64'(overrun), 64'd1);
        run_packet(16'h0000, 16'h0001, PERIOD, 0, 0, 0);
        check("overrun_hold", 64'(overrun), 64'd1);
        enable = 1'b0;
        @(negedge clk);
        check("overrun_clr", 64'(overrun), 64'd0);
        repeat (20) @(negedge clk);
        check("idle_after", 64'({busy, fifo_rd_en, tx_valid}), 64'd0);

        // Frame counter wrap: hold frame_start for 65535 samples to reach FFFF.
        frame_start = 1'b1;
        repeat (65535) @(negedge clk);
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check("fs_ffff", 64'({FS_mark, pkt_seq}), 64'({16'hFFFF, 16'h0000}));
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check("fs_wrap", 64'({FS_mark, pkt_seq}), 64'({16'h0000, 16'h0000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
